trigger_seq_node: RTL

- Next-generation trigger/capture-address node for the on-chip logic watcher.
- Generalises the single-condition trigger into a SEQ_STAGES-deep sequential trigger:
  - per-stage edge modes and AND/OR logic
  - per-stage occurrence counters
  - programmable post-trigger length
- Drives the sample-buffer BRAM write port (circular buffer, 2^ADDR_W entries) and reports stop address and overflow to the JTAG config/status block.
- Runs on one clock; config inputs are quasi-static, sampled only at arm.

---
 rtl/trigger_seq_node_pkg.sv | 51 +++++
 rtl/trigger_seq_node_if.sv | 41 ++++
 rtl/trigger_seq_node_stage_match.sv | 39 +++
 rtl/trigger_seq_node.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/trigger_seq_node_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trigger_seq_pkg
// Brief    : Shared encodings for the sequential trigger node: edge modes,
//            stage logic selection, FSM states and per-channel helpers.
// Revision : 1.0 - initial release
// ============================================================================
package trigger_seq_pkg;

  localparam logic [2:0] EM_DIS  = 3'd0;
  localparam logic [2:0] EM_LOW  = 3'd1;
  localparam logic [2:0] EM_HIGH = 3'd2;
  localparam logic [2:0] EM_RISE = 3'd3;
  localparam logic [2:0] EM_FALL = 3'd4;
  localparam logic [2:0] EM_ANY  = 3'd5;

  localparam logic LOGIC_AND = 1'b0;
  localparam logic LOGIC_OR  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trig_state_t;

  // Codes 110/111 fall outside the range and act as disabled.
  function automatic logic chan_enabled(input logic [2:0] mode);
    return (mode >= EM_LOW) && (mode <= EM_ANY);
  endfunction

  // Edge modes only fire once a previous sampled value exists.
  function automatic logic chan_true(input logic [2:0] mode,
                                     input logic       prev_b,
                                     input logic       cur_b,
                                     input logic       has_prev);
    logic res;
    res = 1'b0;
    case (mode)
      EM_LOW:  res = ~cur_b;
      EM_HIGH: res = cur_b;
      EM_RISE: res = has_prev & ~prev_b & cur_b;
      EM_FALL: res = has_prev & prev_b & ~cur_b;
      EM_ANY:  res = has_prev & (prev_b ^ cur_b);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trigger_seq_node_if.sv
`default_nettype none
// ============================================================================
// Module   : trigger_seq_node_if
// Brief    : Control, configuration, BRAM write port and status bundle of
//            the sequential trigger node.
// Revision : 1.0 - initial release
// ============================================================================
interface trigger_seq_node_if #(
  parameter int DET_NUM    = 13,
  parameter int ADDR_W     = 10,
  parameter int SEQ_STAGES = 2,
  parameter int CNT_W      = 16
);
  logic                            arm;
  logic                            pause;
  logic [DET_NUM-1:0]              trig_din;
  logic [SEQ_STAGES*DET_NUM*3-1:0] trig_edge_mode;
  logic [SEQ_STAGES-1:0]           trig_logic;
  logic [SEQ_STAGES*CNT_W-1:0]     trig_count;
  logic [ADDR_W-1:0]               post_len;

  logic                            wt_ce;
  logic                            wt_en;
  logic [ADDR_W-1:0]               wt_addr;
  logic                            stop_flag;
  logic [ADDR_W-1:0]               stop_addr;
  logic                            overflow_flag;
  logic [2:0]                      stage_idx;
  logic                            busy;

  modport master (
    output arm, pause, trig_din, trig_edge_mode, trig_logic, trig_count, post_len,
    input  wt_ce, wt_en, wt_addr, stop_flag, stop_addr, overflow_flag, stage_idx, busy
  );

  modport slave (
    input  arm, pause, trig_din, trig_edge_mode, trig_logic, trig_count, post_len,
    output wt_ce, wt_en, wt_addr, stop_flag, stop_addr, overflow_flag, stage_idx, busy
  );
endinterface
`default_nettype wire

// File: rtl/trigger_seq_node_stage_match.sv
`default_nettype none
// ============================================================================
// Module   : trigger_stage_match
// Brief    : Combinational match of one trigger stage against the current and
//            previous sampled probe values.
// Revision : 1.0 - initial release
// ============================================================================
module trigger_stage_match
  import trigger_seq_pkg::*;
#(
  parameter int DET_NUM = 13
) (
  input  logic [DET_NUM-1:0]   i_prev,
  input  logic [DET_NUM-1:0]   i_cur,
  input  logic                 i_has_prev,
  input  logic [DET_NUM*3-1:0] i_mode,
  input  logic                 i_logic,
  output logic                 o_match
);

  logic [DET_NUM-1:0] w_en;
  logic [DET_NUM-1:0] w_true;

  for (genvar c = 0; c < DET_NUM; c++) begin : g_chan
    assign w_en[c]   = chan_enabled(i_mode[c*3 +: 3]);
    assign w_true[c] = chan_true(i_mode[c*3 +: 3], i_prev[c], i_cur[c], i_has_prev);
  end

  // Disabled channels are neutral; a stage with none enabled always matches.
  always_comb begin
    o_match = 1'b1;
    if (|w_en) begin
      if (i_logic == LOGIC_OR) o_match = |(w_true & w_en);
      else                     o_match = &(w_true | ~w_en);
    end
  end

endmodule
`default_nettype wire

// File: rtl/trigger_seq_node.sv
`default_nettype none
// ============================================================================
// Module   : trigger_seq_node
// Brief    : Multi-stage sequential trigger with occurrence counters, post-
//            trigger length and circular sample-buffer write addressing.
// Revision : 1.0 - initial release
// ============================================================================
module trigger_seq_node
  import trigger_seq_pkg::*;
#(
  parameter int DET_NUM    = 13,
  parameter int ADDR_W     = 10,
  parameter int SEQ_STAGES = 2,
  parameter int CNT_W      = 16
) (
  input  logic               trig_clk,
  input  logic               trig_rst,
  trigger_seq_node_if.slave  bus
);

  localparam int MODE_W = SEQ_STAGES*DET_NUM*3;

  trig_state_t                 r_state, w_state_nxt;
  logic [MODE_W-1:0]           r_cfg_mode;
  logic [SEQ_STAGES-1:0]       r_cfg_logic;
  logic [SEQ_STAGES*CNT_W-1:0] r_cfg_count;
  logic [ADDR_W-1:0]           r_cfg_post_len;
  logic [DET_NUM-1:0]          r_prev;
  logic                        r_has_prev;
  logic [2:0]                  r_stage;
  logic [CNT_W-1:0]            r_count;
  logic [ADDR_W-1:0]           r_addr, r_post_cnt, r_wt_addr, r_stop_addr;
  logic                        r_wt_en, r_stop_flag, r_overflow;

  logic [SEQ_STAGES-1:0]       w_match_vec;
  logic                        w_match_sel;
  logic [CNT_W-1:0]            w_cnt_raw, w_target;
  logic                        w_busy, w_sample, w_final, w_stage_hit, w_trig;

  for (genvar s = 0; s < SEQ_STAGES; s++) begin : g_stage
    trigger_stage_match #(.DET_NUM(DET_NUM)) u_match (
      .i_prev     (r_prev),
      .i_cur      (bus.trig_din),
      .i_has_prev (r_has_prev),
      .i_mode     (r_cfg_mode[s*DET_NUM*3 +: DET_NUM*3]),
      .i_logic    (r_cfg_logic[s]),
      .o_match    (w_match_vec[s])
    );
  end

  // Select the active stage's match and occurrence target; 0 counts as 1.
  always_comb begin
    w_match_sel = 1'b0;
    w_cnt_raw   = '0;
    for (int s = 0; s < SEQ_STAGES; s++) begin
      if (r_stage == 3'(s)) begin
        w_match_sel = w_match_vec[s];
        w_cnt_raw   = r_cfg_count[s*CNT_W +: CNT_W];
      end
    end
    w_target    = (w_cnt_raw == '0) ? CNT_W'(1) : w_cnt_raw;
    w_stage_hit = w_match_sel && (r_count == w_target - CNT_W'(1));
    w_final     = (r_stage == 3'(SEQ_STAGES-1));
    w_busy      = (r_state == ARMED) || (r_state == POST);
    // arm takes priority, so the arm cycle itself is never sampled.
    w_sample    = w_busy && !bus.pause && !bus.arm;
    w_trig      = w_sample && (r_state == ARMED) && w_stage_hit && w_final;
  end

  // Next-state logic; arm restarts from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.arm) begin
      w_state_nxt = ARMED;
    end else begin
      case (r_state)
        ARMED:   if (w_trig) w_state_nxt = (r_cfg_post_len == '0) ? DONE : POST;
        POST:    if (w_sample && (r_post_cnt == ADDR_W'(1))) w_state_nxt = DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge trig_clk or posedge trig_rst) begin
    if (trig_rst) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Config latch, stage counters, write addressing and status flags.
  always_ff @(posedge trig_clk or posedge trig_rst) begin
    if (trig_rst) begin
      r_cfg_mode     <= '0;
      r_cfg_logic    <= '0;
      r_cfg_count    <= '0;
      r_cfg_post_len <= '0;
      r_prev         <= '0;
      r_has_prev     <= 1'b0;
      r_stage        <= '0;
      r_count        <= '0;
      r_addr         <= '0;
      r_post_cnt     <= '0;
      r_wt_addr      <= '0;
      r_stop_addr    <= '0;
      r_wt_en        <= 1'b0;
      r_stop_flag    <= 1'b0;
      r_overflow     <= 1'b0;
    end else if (bus.arm) begin
      r_cfg_mode     <= bus.trig_edge_mode;
      r_cfg_logic    <= bus.trig_logic;
      r_cfg_count    <= bus.trig_count;
      r_cfg_post_len <= bus.post_len;
      r_has_prev     <= 1'b0;
      r_stage        <= '0;
      r_count        <= '0;
      r_addr         <= '0;
      r_post_cnt     <= '0;
      r_wt_addr      <= '0;
      r_wt_en        <= 1'b0;
      r_stop_flag    <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_wt_en     <= w_sample;
      r_stop_flag <= (r_state == DONE);
      if (w_sample) begin
        r_wt_addr  <= r_addr;
        r_addr     <= r_addr + 1'b1;
        r_prev     <= bus.trig_din;
        r_has_prev <= 1'b1;
        if (r_state == ARMED) begin
          if (r_addr == '1) r_overflow <= 1'b1;
          if (w_stage_hit) begin
            r_count <= '0;
            if (w_final) begin
              r_stop_addr <= r_addr;
              r_post_cnt  <= r_cfg_post_len;
            end else begin
              r_stage <= r_stage + 3'd1;
            end
          end else if (w_match_sel) begin
            r_count <= r_count + 1'b1;
          end
        end else begin
          r_post_cnt <= r_post_cnt - 1'b1;
        end
      end
    end
  end

  assign bus.wt_ce         = r_wt_en;
  assign bus.wt_en         = r_wt_en;
  assign bus.wt_addr       = r_wt_addr;
  assign bus.stop_flag     = r_stop_flag;
  assign bus.stop_addr     = r_stop_addr;
  assign bus.overflow_flag = r_overflow;
  assign bus.stage_idx     = r_stage;
  assign bus.busy          = w_busy;

endmodule
`default_nettype wire
